instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of instruction buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of in-flight memory requests.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream.
REQ-005 pc  in  32  current fetch address from the program counter stage.
REQ-006 pc_advance  out  1  drives the program counter write_enable; PC increments by 4.
REQ-007 redirect  in  1  a taken branch/jump is being loaded into the PC this cycle.
REQ-008 imem_req_valid  out  1  fetch request valid.
REQ-009 imem_req_ready  in  1  memory accepts the request.
REQ-010 imem_req_addr  out  32  request address; SHALL equal pc.
REQ-011 imem_rsp_valid  in  1  read data valid; responses return in order, at least 1 cycle after acceptance.
REQ-012 imem_rsp_data  in  32  instruction word.
REQ-013 instr_valid / instr_ready  out / in  1 / 1  decode-side handshake.
REQ-014 instr_data / instr_pc  out / out  32 / 32  instruction word and its address.

Function
REQ-015 Request acceptance ("accept") SHALL mean imem_req_valid & imem_req_ready.
REQ-016 imem_req_valid SHALL be 1 only when all of the following hold: not in reset, redirect = 0, outstanding < MAX_OUTSTANDING, and fifo_count + live_outstanding < FIFO_DEPTH.
REQ-017 pc_advance SHALL equal accept (combinational), so exactly one PC increment occurs per accepted request.
REQ-018 On accept, the accepted pc SHALL be pushed into an internal address queue (MAX_OUTSTANDING deep) tagged live.
REQ-019 On imem_rsp_valid, the head of the address queue SHALL pop.
  - If the popped entry is live, {pc, data} SHALL be written into the FIFO.
  - If it is stale, the response SHALL be discarded.
REQ-020 The FIFO output SHALL be first-word-through: instr_valid = (fifo_count != 0), and instr_data/instr_pc SHALL come from the head entry.
REQ-021 The FIFO SHALL pop when instr_valid & instr_ready.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged; a push to a full FIFO SHALL be impossible by construction (REQ-016).
REQ-023 On redirect = 1, at that clock edge:
  - the FIFO SHALL be flushed (count = 0);
  - all queued outstanding entries SHALL be marked stale;
  - instr_valid SHALL be 0 from the next cycle;
  - a response arriving in the same cycle SHALL be discarded.
REQ-024 After a redirect, fetching SHALL resume the next cycle from the new pc; no instruction from the old path SHALL reach decode.
REQ-025 instr_valid/instr_data/instr_pc SHALL hold stable while instr_valid = 1 and instr_ready = 0.
REQ-026 Pointers SHALL wrap modulo depth; counters SHALL be sized ceil(log2(depth + 1)) bits.
REQ-027 A response with an empty address queue is illegal; the block SHALL raise an assertion in simulation.

Reset
REQ-028 While rst = 0 the block SHALL drive: imem_req_valid = 0, pc_advance = 0, instr_valid = 0, instr_data = 0, instr_pc = 0.
REQ-029 While rst = 0, all counts and pointers SHALL be 0 and all stale tags SHALL be cleared.
REQ-030 A response arriving during or after a mid-operation reset for a pre-reset request SHALL be ignored.
  - The memory SHALL also be reset; verification SHALL check this.
REQ-031 The first request SHALL be issued in the first cycle after rst deasserts, with imem_req_addr = 0x01000000.

Structure
REQ-032 FIFO_DEPTH and MAX_OUTSTANDING defaults, NOP word 0x00000013 and the fetch-entry layout {pc[31:0], instr[31:0]} SHALL live in the shared defines header.
REQ-033 The instruction buffer SHALL be a sub-module, fetch_fifo (parameterised width/depth, with push, pop, flush, count, full and empty).

Verification
REQ-034 Reset release, ready = 1, 1-cycle response latency, instr_ready = 1 -> requests at 0x01000000, 0x01000004, 0x01000008; instr_pc follows in order with data intact.
REQ-035 instr_ready = 0 for 10 cycles -> exactly 2 entries are buffered, imem_req_valid = 0 while full, pc_advance count = 2, no data loss on release.
REQ-036 Redirect to 0x01000100 with 2 requests outstanding -> both responses are dropped, the next instr_pc = 0x01000100, and the FIFO is empty the cycle after redirect.
REQ-037 Redirect in the same cycle as imem_req_ready and imem_rsp_valid -> no accept, no pc_advance, the response is discarded.
REQ-038 rst asserted mid-fetch with a response pending -> all outputs go to 0 immediately; after release the first request is at 0x01000000.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-unit definitions: buffer sizing defaults, NOP encoding and
// the layout of one buffered fetch entry.
package instruction_fetch_pkg;

    localparam int FETCH_FIFO_DEPTH      = 2;
    localparam int FETCH_MAX_OUTSTANDING = 2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/instruction_fetch_fifo.sv
// First-word-through instruction buffer with push/pop/flush and an
// occupancy count; pointers wrap modulo DEPTH.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wrap_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = wrap_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: issues in-order imem requests, tags them live/stale across
// redirects, and buffers returned {pc, instr} pairs for decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH      = FETCH_FIFO_DEPTH,
    parameter int MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_advance,
    input  logic        redirect,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]                aq_pc_q [MAX_OUTSTANDING];
    logic [31:0]                aq_pc_d [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] aq_live_q, aq_live_d;
    logic [QPW-1:0]             aq_wr_q, aq_wr_d;
    logic [QPW-1:0]             aq_rd_q, aq_rd_d;
    logic [OCW-1:0]             out_cnt_q, out_cnt_d;
    logic [OCW-1:0]             live_cnt_q, live_cnt_d;

    logic           accept, rsp_pop, head_live;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FCW-1:0] fifo_count;
    fetch_entry_t   fifo_in, fifo_out;

    function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
        return (p == QPW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Stale entries still occupy a memory slot but never a buffer slot.
    assign imem_req_valid = rst & ~redirect
                          & (int'(out_cnt_q) < MAX_OUTSTANDING)
                          & ((int'(fifo_count) + int'(live_cnt_q)) < FIFO_DEPTH);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid & imem_req_ready;
    assign pc_advance     = accept;

    assign rsp_pop   = imem_rsp_valid & (out_cnt_q != '0);
    assign head_live = aq_live_q[aq_rd_q];
    assign fifo_push = rsp_pop & head_live & ~redirect;
    assign fifo_pop  = ~fifo_empty & instr_ready;
    assign fifo_in   = '{pc: aq_pc_q[aq_rd_q], instr: imem_rsp_data};

    assign instr_valid = ~fifo_empty;
    assign instr_pc    = instr_valid ? fifo_out.pc : '0;
    assign instr_data  = instr_valid ? fifo_out.instr : '0;

    always_comb begin
        aq_pc_d    = aq_pc_q;
        aq_live_d  = aq_live_q;
        aq_wr_d    = aq_wr_q;
        aq_rd_d    = aq_rd_q;
        out_cnt_d  = out_cnt_q + OCW'(accept) - OCW'(rsp_pop);
        live_cnt_d = live_cnt_q + OCW'(accept) - OCW'(rsp_pop & head_live);
        if (accept) begin
            aq_pc_d[aq_wr_q]   = pc;
            aq_live_d[aq_wr_q] = 1'b1;
            aq_wr_d            = q_inc(aq_wr_q);
        end
        if (rsp_pop) begin
            aq_live_d[aq_rd_q] = 1'b0;
            aq_rd_d            = q_inc(aq_rd_q);
        end
        if (redirect) begin
            aq_live_d  = '0;
            live_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) aq_pc_q[i] <= '0;
            aq_live_q  <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            out_cnt_q  <= '0;
            live_cnt_q <= '0;
        end else begin
            aq_pc_q    <= aq_pc_d;
            aq_live_q  <= aq_live_d;
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
            out_cnt_q  <= out_cnt_d;
            live_cnt_q <= live_cnt_d;
        end
    end

    fetch_fifo #(
        .WIDTH(FETCH_ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (fifo_push),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .flush    (redirect),
        .pop_data (fifo_out),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    a_rsp_has_req: assert property (
        @(posedge clk) disable iff (!rst) imem_rsp_valid |-> out_cnt_q != '0);

    a_no_full_push: assert property (
        @(posedge clk) disable iff (!rst) fifo_push |-> !fifo_full);

endmodule
